// File: rtl/frag_depth_writer_if.sv
// Fragment-generator to depth-writer link: fragment handshake inbound,
// framebuffer pixel write outbound.
interface frag_depth_writer_if #(
  parameter int DEPTH_W = 24
);
  logic                frag_val;
  logic [31:0]         x_in;
  logic [31:0]         y_in;
  logic signed [31:0]  w0_in;
  logic signed [31:0]  w1_in;
  logic signed [31:0]  w2_in;
  logic                gen_done;
  logic                pop_frag;
  logic                fb_we;
  logic [31:0]         fb_addr;
  logic [DEPTH_W-1:0]  fb_depth;

  modport master (
    output frag_val, x_in, y_in, w0_in, w1_in, w2_in, gen_done,
    input  pop_frag, fb_we, fb_addr, fb_depth
  );

  modport slave (
    input  frag_val, x_in, y_in, w0_in, w1_in, w2_in, gen_done,
    output pop_frag, fb_we, fb_addr, fb_depth
  );
endinterface

// File: rtl/frag_depth_writer.sv
// Pops fragments, interpolates depth from barycentric weights, depth-tests
// against an internal z-buffer and issues framebuffer writes for survivors.
//
// state | meaning
// IDLE  | waiting; clear or pop a fragment
// CLEAR | write all-ones to one z-buffer word per cycle
// MUL   | zsum = sum of w_i * z_i
// SCALE | scale by 1/area, clamp, bounds check
// READ  | read stored depth
// CMP   | depth test, write on pass
module frag_depth_writer #(
  parameter int WIDTH     = 64,
  parameter int HEIGHT    = 64,
  parameter int DEPTH_W   = 24,
  parameter int FRAC_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                start,
  input  logic [31:0]         recip_area,
  input  logic signed [31:0]  v0_raster_z,
  input  logic signed [31:0]  v1_raster_z,
  input  logic signed [31:0]  v2_raster_z,
  frag_depth_writer_if.slave  frag,
  output logic                busy,
  output logic                frame_done,
  output logic [31:0]         pass_cnt,
  output logic [31:0]         fail_cnt
);
  localparam int NPIX = WIDTH * HEIGHT;
  localparam int AW   = $clog2(NPIX);
  localparam logic [DEPTH_W-1:0] DMAX = '1;

  typedef enum logic [2:0] {IDLE, CLEAR, MUL, SCALE, READ, CMP} state_t;
  state_t state_q, state_d;

  logic [31:0]        recip_q, recip_f;
  logic signed [31:0] z0_q, z1_q, z2_q, zf0, zf1, zf2;
  logic [31:0]        x_q, y_q;
  logic signed [31:0] w0_q, w1_q, w2_q;
  logic signed [65:0] zsum_q, zsum_d;
  logic signed [98:0] scaled, shifted;
  logic [DEPTH_W-1:0] d_q, d_d, rd_q, fb_depth_q;
  logic [AW-1:0]      addr_q, addr_d, clr_addr_q;
  logic [31:0]        fb_addr_q;
  logic               in_bounds, pass, pop_d, we_d;

  logic [DEPTH_W-1:0] zbuf [NPIX];

  always_comb begin
    zsum_d  = 66'(w0_q) * 66'(zf0) + 66'(w1_q) * 66'(zf1) + 66'(w2_q) * 66'(zf2);
    scaled  = 99'(zsum_q) * $signed(99'(recip_f));
    shifted = scaled >>> FRAC_BITS;
    if (shifted[98])
      d_d = '0;
    else if (|shifted[97:DEPTH_W])
      d_d = DMAX;
    else
      d_d = shifted[DEPTH_W-1:0];
    in_bounds = (x_q < 32'(WIDTH)) && (y_q < 32'(HEIGHT));
    // Only the in-bounds address is ever used, so AW bits are exact.
    addr_d = AW'(y_q) * AW'(WIDTH) + AW'(x_q);
    pass   = d_q < rd_q;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop_d   = 1'b0;
    we_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = CLEAR;
        end else if (frag.frag_val) begin
          pop_d   = 1'b1;
          state_d = MUL;
        end
      end
      CLEAR:   if (clr_addr_q == AW'(NPIX - 1)) state_d = IDLE;
      MUL:     state_d = SCALE;
      SCALE:   state_d = in_bounds ? READ : IDLE;
      READ:    state_d = CMP;
      CMP: begin
        we_d    = pass;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are gated by rst so an abort produces no pop or write that cycle.
  assign frag.pop_frag = pop_d & ~rst;
  assign frag.fb_we    = we_d & ~rst;
  assign frag.fb_addr  = frag.fb_we ? 32'(addr_q) : fb_addr_q;
  assign frag.fb_depth = frag.fb_we ? d_q : fb_depth_q;
  assign busy          = (state_q != IDLE) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      recip_q    <= '0;
      z0_q       <= '0;
      z1_q       <= '0;
      z2_q       <= '0;
      recip_f    <= '0;
      zf0        <= '0;
      zf1        <= '0;
      zf2        <= '0;
      x_q        <= '0;
      y_q        <= '0;
      w0_q       <= '0;
      w1_q       <= '0;
      w2_q       <= '0;
      zsum_q     <= '0;
      d_q        <= '0;
      rd_q       <= '0;
      addr_q     <= '0;
      clr_addr_q <= '0;
      fb_addr_q  <= '0;
      fb_depth_q <= '0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      frame_done <= 1'b0;
    end else begin
      if (start) begin
        recip_q <= recip_area;
        z0_q    <= v0_raster_z;
        z1_q    <= v1_raster_z;
        z2_q    <= v2_raster_z;
      end
      // Snapshot constants at pop so a later start cannot affect this fragment.
      if (pop_d) begin
        x_q     <= frag.x_in;
        y_q     <= frag.y_in;
        w0_q    <= frag.w0_in;
        w1_q    <= frag.w1_in;
        w2_q    <= frag.w2_in;
        zf0     <= z0_q;
        zf1     <= z1_q;
        zf2     <= z2_q;
        recip_f <= recip_q;
      end
      case (state_q)
        IDLE:  if (clear) clr_addr_q <= '0;
        CLEAR: clr_addr_q <= clr_addr_q + AW'(1);
        MUL:   zsum_q <= zsum_d;
        SCALE: begin
          d_q    <= d_d;
          addr_q <= addr_d;
          if (!in_bounds) fail_cnt <= fail_cnt + 32'd1;
        end
        READ:  rd_q <= zbuf[addr_q];
        CMP: begin
          if (pass) begin
            pass_cnt   <= pass_cnt + 32'd1;
            fb_addr_q  <= 32'(addr_q);
            fb_depth_q <= d_q;
          end else begin
            fail_cnt <= fail_cnt + 32'd1;
          end
        end
        default: ;
      endcase
      if (start || clear)
        frame_done <= 1'b0;
      else if (state_q == IDLE && frag.gen_done && !frag.frag_val)
        frame_done <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR)
        zbuf[clr_addr_q] <= DMAX;
      else if (we_d)
        zbuf[addr_q] <= d_q;
    end
  end
endmodule

// File: tb/tb_frag_depth_writer.sv
// Directed bench for frag_depth_writer: clear, depth test, bounds, clamping,
// back-to-back throughput, frame_done and mid-flight reset.
module tb_frag_depth_writer;
  logic               clk = 1'b0;
  logic               rst, clear, start;
  logic [31:0]        recip_area;
  logic signed [31:0] v0, v1, v2;
  logic               busy, frame_done;
  logic [31:0]        pass_cnt, fail_cnt;
  int checks = 0;
  int failures = 0;

  frag_depth_writer_if #(.DEPTH_W(24)) fif ();

  frag_depth_writer #(.WIDTH(64), .HEIGHT(64), .DEPTH_W(24), .FRAC_BITS(16)) dut (
    .clk(clk), .rst(rst), .clear(clear), .start(start), .recip_area(recip_area),
    .v0_raster_z(v0), .v1_raster_z(v1), .v2_raster_z(v2), .frag(fif),
    .busy(busy), .frame_done(frame_done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic set_tri(input logic [31:0] r, input int z0, input int z1, input int z2);
    @(posedge clk); #1;
    start = 1'b1; recip_area = r; v0 = z0; v1 = z1; v2 = z2;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_frag(input int x, input int y, input int w0, input int w1, input int w2,
                          output logic popped, output logic we_seen, output int lat,
                          output logic [31:0] addr, output logic [23:0] depth);
    @(posedge clk); #1;
    fif.frag_val = 1'b1; fif.x_in = x; fif.y_in = y;
    fif.w0_in = w0; fif.w1_in = w1; fif.w2_in = w2;
    @(negedge clk);
    popped = fif.pop_frag;
    @(posedge clk); #1;
    fif.frag_val = 1'b0;
    we_seen = 1'b0; lat = -1; addr = '0; depth = '0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (fif.fb_we && !we_seen) begin
        we_seen = 1'b1; lat = k; addr = fif.fb_addr; depth = fif.fb_depth;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (fif.pop_frag !== 1'b0) begin failures++; $display("FAIL reset_pop: got %b expected 0", fif.pop_frag); end
    checks++; if (fif.fb_we !== 1'b0) begin failures++; $display("FAIL reset_we: got %b expected 0", fif.fb_we); end
    checks++; if (fif.fb_addr !== 32'd0) begin failures++; $display("FAIL reset_addr: got %0h expected 0", fif.fb_addr); end
    checks++; if (fif.fb_depth !== 24'd0) begin failures++; $display("FAIL reset_depth: got %0h expected 0", fif.fb_depth); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    checks++; if (pass_cnt !== 32'd0) begin failures++; $display("FAIL reset_pass_cnt: got %0d expected 0", pass_cnt); end
    checks++; if (fail_cnt !== 32'd0) begin failures++; $display("FAIL reset_fail_cnt: got %0d expected 0", fail_cnt); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_clear;
    int cnt = 0;
    logic pop_seen = 1'b0;
    @(posedge clk); #1; clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
      if (fif.pop_frag) pop_seen = 1'b1;
      if (i == 100) begin clear = 1'b1; fif.frag_val = 1'b1; end
      if (i == 110) begin clear = 1'b0; fif.frag_val = 1'b0; end
    end
    checks++; if (cnt !== 4096) begin failures++; $display("FAIL clear_busy_cycles: got %0d expected 4096", cnt); end
    checks++; if (pop_seen !== 1'b0) begin failures++; $display("FAIL clear_no_pop: got %b expected 0", pop_seen); end
    checks++; if (fif.pop_frag !== 1'b0) begin failures++; $display("FAIL clear_idle_pop: got %b expected 0", fif.pop_frag); end
  endtask

  task automatic test_depth_pass;
    logic p, we; int lat; logic [31:0] a; logic [23:0] d;
    set_tri(32'h10000, 100, 200, 300);
    run_frag(3, 2, 1, 0, 0, p, we, lat, a, d);
    checks++; if (p !== 1'b1) begin failures++; $display("FAIL pass_pop: got %b expected 1", p); end
    checks++; if (we !== 1'b1) begin failures++; $display("FAIL pass_we: got %b expected 1", we); end
    checks++; if (lat !== 4) begin failures++; $display("FAIL pass_latency: got %0d expected 4", lat); end
    checks++; if (a !== 32'd131) begin failures++; $display("FAIL pass_addr: got %0d expected 131", a); end
    checks++; if (d !== 24'd100) begin failures++; $display("FAIL pass_depth: got %0d expected 100", d); end
    checks++; if (pass_cnt !== 32'd1) begin failures++; $display("FAIL pass_cnt1: got %0d expected 1", pass_cnt); end
  endtask

  task automatic test_depth_fail;
    logic p, we; int lat; logic [31:0] a; logic [23:0] d;
    run_frag(3, 2, 0, 1, 0, p, we, lat, a, d);
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL fail_we: got %b expected 0", we); end
    checks++; if (fail_cnt !== 32'd1) begin failures++; $display("FAIL fail_cnt1: got %0d expected 1", fail_cnt); end
    checks++; if (fif.fb_addr !== 32'd131) begin failures++; $display("FAIL hold_addr: got %0d expected 131", fif.fb_addr); end
    checks++; if (fif.fb_depth !== 24'd100) begin failures++; $display("FAIL hold_depth: got %0d expected 100", fif.fb_depth); end
    run_frag(3, 2, 0, 0, 0, p, we, lat, a, d);
    checks++; if (we !== 1'b1) begin failures++; $display("FAIL zero_we: got %b expected 1", we); end
    checks++; if (d !== 24'd0) begin failures++; $display("FAIL zero_depth: got %0d expected 0", d); end
    checks++; if (pass_cnt !== 32'd2) begin failures++; $display("FAIL pass_cnt2: got %0d expected 2", pass_cnt); end
  endtask

  task automatic test_bounds;
    logic p, we; int lat; logic [31:0] a; logic [23:0] d;
    run_frag(64, 0, 1, 0, 0, p, we, lat, a, d);
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL oob_x_we: got %b expected 0", we); end
    checks++; if (fail_cnt !== 32'd2) begin failures++; $display("FAIL oob_x_cnt: got %0d expected 2", fail_cnt); end
    run_frag(0, 64, 1, 0, 0, p, we, lat, a, d);
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL oob_y_we: got %b expected 0", we); end
    checks++; if (fail_cnt !== 32'd3) begin failures++; $display("FAIL oob_y_cnt: got %0d expected 3", fail_cnt); end
    run_frag(63, 63, 1, 0, 0, p, we, lat, a, d);
    checks++; if (we !== 1'b1) begin failures++; $display("FAIL corner_we: got %b expected 1", we); end
    checks++; if (a !== 32'd4095) begin failures++; $display("FAIL corner_addr: got %0d expected 4095", a); end
    checks++; if (pass_cnt !== 32'd3) begin failures++; $display("FAIL pass_cnt3: got %0d expected 3", pass_cnt); end
  endtask

  task automatic test_clamp;
    logic p, we; int lat; logic [31:0] a; logic [23:0] d;
    run_frag(5, 5, -1, 0, 0, p, we, lat, a, d);
    checks++; if (we !== 1'b1) begin failures++; $display("FAIL neg_we: got %b expected 1", we); end
    checks++; if (d !== 24'd0) begin failures++; $display("FAIL neg_depth: got %0d expected 0", d); end
    checks++; if (a !== 32'd325) begin failures++; $display("FAIL neg_addr: got %0d expected 325", a); end
    // 0x100000*100 exceeds 24 bits; clamped to all-ones it cannot beat the cleared buffer.
    run_frag(6, 5, 32'h100000, 0, 0, p, we, lat, a, d);
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL big_we: got %b expected 0", we); end
    checks++; if (fail_cnt !== 32'd4) begin failures++; $display("FAIL big_cnt: got %0d expected 4", fail_cnt); end
    checks++; if (pass_cnt !== 32'd4) begin failures++; $display("FAIL pass_cnt4: got %0d expected 4", pass_cnt); end
  endtask

  task automatic test_back_to_back;
    int pop_t[3] = '{0, 0, 0};
    logic [31:0] wa[3] = '{0, 0, 0};
    logic [23:0] wd[3] = '{0, 0, 0};
    int np = 0, nw = 0;
    logic popped, fd_at_last = 1'b1;
    set_tri(32'h8000, 1000, 2000, 3000);
    @(posedge clk); #1;
    fif.frag_val = 1'b1; fif.x_in = 10; fif.y_in = 1;
    fif.w0_in = 1; fif.w1_in = 0; fif.w2_in = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      popped = 1'b0;
      if (fif.pop_frag && np < 3) begin pop_t[np] = c; np++; popped = 1'b1; end
      if (fif.fb_we && nw < 3) begin
        wa[nw] = fif.fb_addr; wd[nw] = fif.fb_depth;
        if (nw == 2) fd_at_last = frame_done;
        nw++;
      end
      @(posedge clk); #1;
      if (popped) begin
        if (np < 3) begin
          fif.x_in = 10 + np;
          fif.w0_in = 0; fif.w1_in = (np == 1) ? 1 : 0; fif.w2_in = (np == 2) ? 1 : 0;
        end else begin
          fif.frag_val = 1'b0; fif.gen_done = 1'b1;
        end
      end
    end
    checks++; if (np !== 3) begin failures++; $display("FAIL b2b_pops: got %0d expected 3", np); end
    checks++; if (pop_t[1] - pop_t[0] !== 5) begin failures++; $display("FAIL b2b_gap1: got %0d expected 5", pop_t[1] - pop_t[0]); end
    checks++; if (pop_t[2] - pop_t[1] !== 5) begin failures++; $display("FAIL b2b_gap2: got %0d expected 5", pop_t[2] - pop_t[1]); end
    checks++; if (nw !== 3) begin failures++; $display("FAIL b2b_writes: got %0d expected 3", nw); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (wa[i] !== 32'(74 + i)) begin failures++; $display("FAIL b2b_addr%0d: got %0d expected %0d", i, wa[i], 74 + i); end
      checks++; if (wd[i] !== 24'(500 * (i + 1))) begin failures++; $display("FAIL b2b_depth%0d: got %0d expected %0d", i, wd[i], 500 * (i + 1)); end
    end
    checks++; if (fd_at_last !== 1'b0) begin failures++; $display("FAIL fd_in_flight: got %b expected 0", fd_at_last); end
    checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL fd_set: got %b expected 1", frame_done); end
    checks++; if (pass_cnt !== 32'd7) begin failures++; $display("FAIL pass_cnt7: got %0d expected 7", pass_cnt); end
    @(posedge clk); #1; start = 1'b1; fif.gen_done = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL fd_cleared: got %b expected 0", frame_done); end
  endtask

  task automatic test_reset_mid;
    logic we_seen = 1'b0;
    @(posedge clk); #1;
    fif.frag_val = 1'b1; fif.x_in = 20; fif.y_in = 20;
    fif.w0_in = 1; fif.w1_in = 0; fif.w2_in = 0;
    @(negedge clk);
    checks++; if (fif.pop_frag !== 1'b1) begin failures++; $display("FAIL mid_pop: got %b expected 1", fif.pop_frag); end
    @(posedge clk); #1; fif.frag_val = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (fif.fb_we) we_seen = 1'b1;
      if (k == 1) rst = 1'b0;
    end
    checks++; if (we_seen !== 1'b0) begin failures++; $display("FAIL mid_we: got %b expected 0", we_seen); end
    checks++; if (pass_cnt !== 32'd0) begin failures++; $display("FAIL mid_pass_cnt: got %0d expected 0", pass_cnt); end
    checks++; if (fail_cnt !== 32'd0) begin failures++; $display("FAIL mid_fail_cnt: got %0d expected 0", fail_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy: got %b expected 0", busy); end
  endtask

  task automatic test_clear_start;
    logic p, we; int lat; logic [31:0] a; logic [23:0] d;
    @(posedge clk); #1;
    clear = 1'b1; start = 1'b1; recip_area = 32'h20000; v0 = 7; v1 = 0; v2 = 0;
    fif.frag_val = 1'b1; fif.x_in = 1; fif.y_in = 1;
    fif.w0_in = 1; fif.w1_in = 0; fif.w2_in = 0;
    @(negedge clk);
    checks++; if (fif.pop_frag !== 1'b0) begin failures++; $display("FAIL prio_pop: got %b expected 0", fif.pop_frag); end
    @(posedge clk); #1; clear = 1'b0; start = 1'b0; fif.frag_val = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL prio_clear: got %b expected 1", busy); end
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL prio_timeout: got %b expected 0", busy); end
    run_frag(1, 1, 1, 0, 0, p, we, lat, a, d);
    checks++; if (we !== 1'b1) begin failures++; $display("FAIL newtri_we: got %b expected 1", we); end
    checks++; if (d !== 24'd14) begin failures++; $display("FAIL newtri_depth: got %0d expected 14", d); end
    checks++; if (a !== 32'd65) begin failures++; $display("FAIL newtri_addr: got %0d expected 65", a); end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; start = 1'b0; recip_area = '0; v0 = 0; v1 = 0; v2 = 0;
    fif.frag_val = 1'b0; fif.x_in = '0; fif.y_in = '0;
    fif.w0_in = '0; fif.w1_in = '0; fif.w2_in = '0; fif.gen_done = 1'b0;
    test_reset();
    test_clear();
    test_depth_pass();
    test_depth_fail();
    test_bounds();
    test_clamp();
    test_back_to_back();
    test_reset_mid();
    test_clear_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/frag_depth_writer.md
Name: frag_depth_writer

Overview:
Consumer end of the fragment-generator output interface. It pops fragments via frag_val/pop_frag, interpolates depth from the barycentric weights and per-triangle vertex z, and depth-tests against an internal z-buffer. Passing fragments update the z-buffer and issue a one-cycle pixel write to the framebuffer port. It sits between the fragment generator and framebuffer/shading logic, and signals frame completion once the generator is done and its own pipeline is empty.

Parameters:
WIDTH, 64, framebuffer width in pixels
HEIGHT, 64, framebuffer height in pixels
DEPTH_W, 24, stored depth width in bits
FRAC_BITS, 16, fractional bits of recip_area (fixed point)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
clear  in  1  pulse: initialise z-buffer to all-ones
start  in  1  pulse: latch triangle constants
recip_area  in  32  unsigned 1/area, Q(32-FRAC_BITS).FRAC_BITS
v0_raster_z  in  32  signed vertex-0 z (integer)
v1_raster_z  in  32  signed vertex-1 z
v2_raster_z  in  32  signed vertex-2 z
frag_val  in  1  fragment available from generator
x_in  in  32  fragment x
y_in  in  32  fragment y
w0_in  in  32  signed edge weight 0
w1_in  in  32  signed edge weight 1
w2_in  in  32  signed edge weight 2
gen_done  in  1  generator finished triangle
pop_frag  out  1  accept/pop current fragment
fb_we  out  1  pixel write strobe
fb_addr  out  32  y*WIDTH + x
fb_depth  out  DEPTH_W  depth written
busy  out  1  clearing or fragment in flight
frame_done  out  1  gen_done seen and pipeline empty
pass_cnt  out  32  fragments that passed the depth test
fail_cnt  out  32  fragments that failed the test or were out of bounds

Behaviour:
- Reset: all outputs 0, counters 0, FSM to IDLE, latched constants 0. Z-buffer contents are undefined after reset.
- start: latches recip_area and z0..z2 in any state. Fragments already in flight use the old constants.
- FSM states: IDLE, CLEAR, MUL, SCALE, READ, CMP.
- IDLE:
  - clear has priority over frag_val. clear → CLEAR.
  - Otherwise, if frag_val: pop_frag=1 for exactly this cycle; capture x, y, w0..w2; go to MUL.
  - pop_frag is 0 in every other state and whenever frag_val=0.
- CLEAR:
  - Writes all-ones to one address per cycle, 0..WIDTH*HEIGHT-1, then returns to IDLE.
  - busy=1 and fragments are not popped.
  - clear asserted during CLEAR is ignored.
- MUL: zsum = w0*z0 + w1*z1 + w2*z2, signed 32x32 products, summed at 66 bits, registered.
- SCALE: d = (zsum * recip_area) >>> FRAC_BITS, arithmetic shift. Clamp: d<0 → 0; d>2^DEPTH_W-1 → 2^DEPTH_W-1. Registered.
- Bounds: x>=WIDTH or y>=HEIGHT, treating x and y as unsigned. Checked in SCALE; on failure go to IDLE, fail_cnt+1, no memory access.
- READ: synchronous z-buffer read at y*WIDTH+x.
- CMP:
  - Pass iff d < stored value (strict less-than).
  - Pass: write d to the z-buffer; fb_we=1 for one cycle with fb_addr and fb_depth; pass_cnt+1.
  - Fail: fail_cnt+1 and fb_we stays 0.
  - Both cases → IDLE.
- Throughput and latency: one fragment per 5 cycles. fb_we is asserted 4 cycles after the pop cycle. fb_addr/fb_depth hold their value until the next write.
- busy=1 in every state except IDLE.
- frame_done:
  - Set in IDLE when the gen_done level is high, frag_val=0 and no fragment is in flight.
  - Cleared by start or clear.
- Counters wrap at 2^32. Both clear on rst only.
- rst mid-operation aborts immediately: no write, pop or count follows.
- clear and start in the same cycle: both take effect.

Test Plan:
- Reset, then clear with WIDTH=HEIGHT=64 → busy high for 4096 cycles, then IDLE with pop_frag=0.
- recip_area=0x10000 (FRAC_BITS=16), z0=100, z1=200, z2=300; fragment x=3, y=2, w=(1,0,0) → pop one cycle, fb_we 4 cycles later, fb_addr=131, fb_depth=100, pass_cnt=1.
- Same pixel again with w=(0,1,0) (d=200) → fb_we stays 0, fail_cnt=1. Then w=(0,0,0) (d=0) → passes, fb_depth=0.
- x=64, y=0 → no fb_we, fail_cnt+1. w0=-1 with z0=100 → d clamped to 0. Huge weights → clamped to 0xFFFFFF.
- frag_val held high with 3 queued fragments → pops spaced exactly 5 cycles apart. Then gen_done=1 with frag_val=0 → frame_done=1 after the last CMP; start → frame_done=0.
- rst asserted in READ → no fb_we, counters 0. clear and frag_val asserted together in IDLE → CLEAR entered, no pop.
